// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: reset / bring-up sequencer for the DDR3 PLL, clocked by the
// free-running 50 MHz reference. It pulses the PLL reset, waits for a stable
// lock, releases the system reset and starts DDR init. It retries on lock
// timeout and recovers on lock loss.
//
// Optional build macro: LOCK_GLITCH_FILTER_EN. When defined, loss of lock in
// WAIT_INIT/RUN is declared only after GLITCH_CYCLES consecutive low samples.
//
// Ports:
//   clk          in   reference clock
//   rst_n        in   asynchronous active-low reset
//   pll_lock     in   PLL lock, asynchronous, synchronized internally
//   soft_rst     in   synchronous request to restart the sequence
//   init_done    in   DDR calibration complete (level)
//   pll_rst      out  PLL reset, active-high
//   sys_rst_n    out  downstream reset, active-low
//   init_start   out  one-cycle DDR init start pulse
//   ready        out  high in RUN only
//   relock_cnt   out  lock-loss event count, saturating at 255
//   timeout_err  out  sticky lock-timeout flag
module pll_lock_rst_seq #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned GLITCH_CYCLES  = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_rst,
    input  logic       init_done,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       init_start,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic       timeout_err
);

    // Reject configurations the counters and synchronizer cannot support.
    if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1 || PLL_RST_CYCLES < 1 ||
        LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || CNT_W < 1 || CNT_W > 32) begin : g_param_err
        $error("pll_lock_rst_seq: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_WAIT_INIT = 3'd3,
        S_RUN       = 3'd4,
        S_LOST      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               lock_s;
    logic               loss_c;
    logic               pll_rst_d, sys_rst_n_d, init_start_d, ready_d, timeout_d;
    logic [7:0]         relock_d;

    // Lock synchronizer; lock_s is the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int unsigned FILT_W = $clog2(GLITCH_CYCLES + 1);

    logic [FILT_W-1:0] filt_q;

    // Counts consecutive low lock samples, saturating at GLITCH_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 filt_q <= '0;
        else if (lock_s)                            filt_q <= '0;
        else if (filt_q != FILT_W'(GLITCH_CYCLES))  filt_q <= filt_q + 1'b1;
    end

    // Loss on the GLITCH_CYCLES-th consecutive low sample.
    assign loss_c = !lock_s && (filt_q >= FILT_W'(GLITCH_CYCLES - 1));
`else
    assign loss_c = !lock_s;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_PLL_RST;
        else        state_q <= state_d;
    end

    // Next state, counter and registered-output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_err;
        relock_d  = relock_cnt;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
                else                                     cnt_d   = cnt_q + 1'b1;
            end
            S_WAIT_LOCK: begin
                if (soft_rst)    state_d = S_PLL_RST;
                else if (lock_s) state_d = S_STABLE;
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d   = S_PLL_RST;
                    timeout_d = 1'b1;
                end
                else             cnt_d   = cnt_q + 1'b1;
            end
            S_STABLE: begin
                if (soft_rst)     state_d = S_PLL_RST;
                else if (!lock_s) state_d = S_WAIT_LOCK;
                else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = S_WAIT_INIT;
                else              cnt_d   = cnt_q + 1'b1;
            end
            S_WAIT_INIT: begin
                if (soft_rst)       state_d = S_PLL_RST;
                else if (loss_c)    state_d = S_LOST;
                else if (init_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (soft_rst)    state_d = S_PLL_RST;
                else if (loss_c) state_d = S_LOST;
            end
            S_LOST: begin
                state_d = S_PLL_RST;
                // A soft restart taking priority here is not a counted loss.
                if (!soft_rst && relock_cnt != 8'hFF) relock_d = relock_cnt + 8'd1;
            end
            default: state_d = S_PLL_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so they register with it.
        pll_rst_d    = (state_d == S_PLL_RST);
        sys_rst_n_d  = (state_d == S_WAIT_INIT) || (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        init_start_d = (state_q == S_STABLE) && (state_d == S_WAIT_INIT);
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            init_start  <= 1'b0;
            ready       <= 1'b0;
            relock_cnt  <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pll_rst     <= pll_rst_d;
            sys_rst_n   <= sys_rst_n_d;
            init_start  <= init_start_d;
            ready       <= ready_d;
            relock_cnt  <= relock_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// tb_pll_lock_rst_seq: directed-plus-random bench for pll_lock_rst_seq.
// Expected latencies are derived arithmetically from the parameters; loss
// events and the sticky timeout flag are tracked by simple scoreboard counters.
module tb_pll_lock_rst_seq;

    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int LT   = 32;
    localparam int SC   = 8;
    localparam int GC   = 4;

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int LOSS_LAT = SYNC + GC;   // edges from pll_lock fall to declared loss
    localparam int LOSS_LEN = GC;          // shortest low pulse that counts as a loss
`else
    localparam int LOSS_LAT = SYNC + 1;
    localparam int LOSS_LEN = 1;
`endif
    // Edges from pll_lock rising (while waiting for lock) to sys_rst_n rising.
    localparam int LOCK_TO_REL = SYNC + 1 + SC;

    localparam int SEL_PLLR = 0;
    localparam int SEL_SYSR = 1;
    localparam int SEL_RDY  = 2;
    localparam int SEL_TERR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       soft_rst = 1'b0;
    logic       init_done = 1'b0;
    logic       pll_rst, sys_rst_n, init_start, ready, timeout_err;
    logic [7:0] relock_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int relock_exp = 0;
    int n, nf, nr, d, j, len;

    pll_lock_rst_seq #(
        .SYNC_STAGES   (SYNC),
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .GLITCH_CYCLES (GC),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .soft_rst   (soft_rst),
        .init_done  (init_done),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .init_start (init_start),
        .ready      (ready),
        .relock_cnt (relock_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(want));
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig_val(input int sel);
        case (sel)
            SEL_PLLR: return pll_rst;
            SEL_SYSR: return sys_rst_n;
            SEL_RDY:  return ready;
            default:  return timeout_err;
        endcase
    endfunction

    // Edges until the selected output takes val; -1 if the budget expires.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int cnt);
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (sig_val(sel) === val) begin
                cnt = i;
                break;
            end
        end
    endtask

    // Drop pll_lock for lo edges; report edges until ready falls and pll_rst rises.
    task automatic pulse_low(input int lo, input int budget, output int f, output int r);
        f = -1;
        r = -1;
        pll_lock = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (i == lo) pll_lock = 1'b1;
            if (f < 0 && ready === 1'b0) f = i;
            if (r < 0 && pll_rst === 1'b1) r = i;
            if (i >= lo && f >= 0 && r >= 0) break;
        end
        pll_lock = 1'b1;
    endtask

    task automatic do_reset(input logic lock, input logic idone);
        rst_n     = 1'b0;
        pll_lock  = lock;
        init_done = idone;
        soft_rst  = 1'b0;
        tick(3);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_init_start", init_start, 0);
        chk("rst_ready", ready, 0);
        chk("rst_relock", relock_cnt, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n      = 1'b1;
        relock_exp = 0;
    endtask

    initial begin
        // Clean bring-up.
        do_reset(1'b1, 1'b0);
        wait_sig(SEL_PLLR, 1'b0, 20, n);
        chk("t1_pll_rst_len", n, PRC);
        wait_sig(SEL_SYSR, 1'b1, 40, n);
        chk("t1_release_lat", n, SC + 1);
        chk("t1_init_start_hi", init_start, 1);
        init_done = 1'b1;
        tick();
        chk("t1_init_start_lo", init_start, 0);
        chk("t1_ready", ready, 1);
        chk("t1_sys_rst_n", sys_rst_n, 1);

        // One-cycle lock chatter inside STABLE restarts the stable count only.
        do_reset(1'b1, 1'b0);
        j = int'($urandom_range(9, 2));
        tick(j + 1);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_sig(SEL_SYSR, 1'b1, 40, n);
        // Last low sample seen SYNC+1 edges after the drop, relock one edge later.
        chk("t3_release_lat", n + 1, SYNC + 2 + SC);
        chk("t3_relock", relock_cnt, 0);
        chk("t3_pll_rst", pll_rst, 0);

        // Lock timeout and retry; later lock completes bring-up.
        do_reset(1'b0, 1'b1);
        wait_sig(SEL_PLLR, 1'b0, 20, n);
        chk("t2_pll_rst_len", n, PRC);
        wait_sig(SEL_TERR, 1'b1, 100, n);
        chk("t2_timeout_lat", n, LT);
        chk("t2_pll_rst_again", pll_rst, 1);
        wait_sig(SEL_PLLR, 1'b0, 20, n);
        chk("t2_pll_rst_len2", n, PRC);
        d = int'($urandom_range(20, 0));
        tick(d);
        pll_lock = 1'b1;
        wait_sig(SEL_SYSR, 1'b1, 60, n);
        chk("t2_release_lat", n, LOCK_TO_REL);
        chk("t2_timeout_sticky", timeout_err, 1);
        tick();
        chk("t2_ready", ready, 1);

        // Lock first seen on the timeout cycle: lock wins.
        do_reset(1'b0, 1'b1);
        wait_sig(SEL_PLLR, 1'b0, 20, n);
        tick(LT - SYNC - 1);
        pll_lock = 1'b1;
        wait_sig(SEL_SYSR, 1'b1, 60, n);
        chk("t2b_release_lat", n, LOCK_TO_REL);
        chk("t2b_no_timeout", timeout_err, 0);

        // Lock one cycle too late: timeout fires.
        do_reset(1'b0, 1'b1);
        wait_sig(SEL_PLLR, 1'b0, 20, n);
        tick(LT - SYNC);
        pll_lock = 1'b1;
        wait_sig(SEL_TERR, 1'b1, 10, n);
        chk("t2c_timeout_lat", n, SYNC);

        // Loss in RUN: 3 low cycles, then 4 low cycles.
        do_reset(1'b1, 1'b1);
        wait_sig(SEL_RDY, 1'b1, 40, n);
        chk("t4_ready_up", n, PRC + SC + 2);
        pulse_low(3, 20, nf, nr);
`ifdef LOCK_GLITCH_FILTER_EN
        chk("t4_l3_ready_fall", nf, -1);
        chk("t4_l3_pll_rst", nr, -1);
`else
        relock_exp++;
        chk("t4_l3_ready_fall", nf, LOSS_LAT);
        chk("t4_l3_pll_rst", nr, LOSS_LAT + 1);
        chk("t4_l3_sys_rst_n", sys_rst_n, 0);
`endif
        wait_sig(SEL_RDY, 1'b1, 80, n);
        chk("t4_l3_recover", n > 0, 1);
        chk("t4_l3_relock", relock_cnt, relock_exp);
        pulse_low(4, 20, nf, nr);
        relock_exp++;
        chk("t4_l4_ready_fall", nf, LOSS_LAT);
        chk("t4_l4_pll_rst", nr, LOSS_LAT + 1);
        wait_sig(SEL_RDY, 1'b1, 80, n);
        chk("t4_l4_recover", n > 0, 1);
        chk("t4_l4_relock", relock_cnt, relock_exp);

        // init_done and loss on the same edge in WAIT_INIT: loss wins.
        do_reset(1'b1, 1'b0);
        wait_sig(SEL_SYSR, 1'b1, 40, n);
        pll_lock = 1'b0;
        tick(LOSS_LAT - 1);
        chk("t5a_still_wait_init", sys_rst_n, 1);
        init_done = 1'b1;
        tick();
        chk("t5a_sys_rst_n", sys_rst_n, 0);
        chk("t5a_ready", ready, 0);
        pll_lock = 1'b1;
        tick();
        chk("t5a_ready_hold", ready, 0);
        chk("t5a_pll_rst", pll_rst, 1);
        relock_exp++;
        wait_sig(SEL_RDY, 1'b1, 80, n);
        chk("t5a_relock", relock_cnt, relock_exp);

        // soft_rst and loss on the same edge in RUN: soft restart wins.
        pll_lock = 1'b0;
        tick(LOSS_LAT - 1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("t5b_pll_rst", pll_rst, 1);
        chk("t5b_ready", ready, 0);
        chk("t5b_sys_rst_n", sys_rst_n, 0);
        pll_lock = 1'b1;
        wait_sig(SEL_RDY, 1'b1, 80, n);
        chk("t5b_recover", n > 0, 1);
        chk("t5b_relock", relock_cnt, relock_exp);

        // Saturation over 260 random-length losses.
        for (int k = 0; k < 260; k++) begin
            len = LOSS_LEN + int'($urandom_range(3, 0));
            pulse_low(len, 20, nf, nr);
            chk("t6_loss_lat", nf, LOSS_LAT);
            if (relock_exp < 255) relock_exp++;
            wait_sig(SEL_RDY, 1'b1, 80, n);
            chk("t6_relock", relock_cnt, relock_exp);
        end
        chk("t6_saturated", relock_cnt, 255);

        // Lock lost for good: timeout after LOST and one PLL reset.
        pll_lock = 1'b0;
        wait_sig(SEL_TERR, 1'b1, 200, n);
        chk("t6_timeout_lat", n, LOSS_LAT + 1 + PRC + LT);
        chk("t6_relock_sat", relock_cnt, 255);

        // Asynchronous reset during STABLE.
        pll_lock = 1'b1;
        wait_sig(SEL_PLLR, 1'b0, 20, n);
        chk("t6_pll_rst_len", n, PRC);
        tick(3);
        chk("t6_in_stable_sys", sys_rst_n, 0);
        chk("t6_in_stable_pll", pll_rst, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pll_rst", pll_rst, 1);
        chk("t6_async_sys_rst_n", sys_rst_n, 0);
        chk("t6_async_init_start", init_start, 0);
        chk("t6_async_ready", ready, 0);
        chk("t6_async_relock", relock_cnt, 0);
        chk("t6_async_timeout", timeout_err, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
